// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_t         : 2-bit FSM state, encodings IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3
//   DEF_MEM_TIMEOUT : default limit on consecutive MEM_WAIT cycles before ERROR
//   DEF_CNT_W       : default width of each performance counter
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low clear
//   i_inc   : count one event on this edge
//   o_count : current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = (r_count == {W{1'b1}});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central pipeline sequencer for the 5-stage core. Merges the load-use
// hazard, the taken-branch signal from ID and the data-memory handshake in
// MEM into one prioritized set of stage enables / flush / bubble controls,
// gates start-up, detects memory timeouts and counts stall/flush events.
//
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   start_i              : level; leaves IDLE on the first edge it is high
//   hazard_i             : load-use hazard for the instruction in ID
//   branch_taken_i       : branch/jump in ID resolved taken
//   EXMEM_MemRead_i/Write: load/store currently in MEM
//   dmem_ack_i           : data memory completes the access this cycle
//   PC_write_o, IFID_write_o : PC and IF/ID enables
//   IFID_flush_o         : clear IF/ID on next edge
//   IDEX_bubble_o        : insert NOP into ID/EX on next edge
//   freeze_o             : hold ID/EX, EX/MEM, MEM/WB
//   dmem_req_o           : data-memory request
//   error_o              : sticky memory-timeout error
//   state_o              : current FSM state (debug visibility)
//   loaduse_cnt_o, flush_cnt_o, memstall_cnt_o : saturating event counters
//
// Memory handshake: dmem_req_o is the valid side and dmem_ack_i the ready
// side. An access completes on the edge where both are high; while req is
// high without ack the request stays asserted and the pipeline is frozen.
// An ack in the same cycle as the request completes with no stall at all.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,  // must be >= 2
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             freeze_o,
  output logic             dmem_req_o,
  output logic             error_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memstall_cnt_o
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic              w_mem_busy;
  logic              w_lu_inc;
  logic              w_fl_inc;
  logic              w_ms_inc;

  // In MEM_WAIT the EX/MEM register is frozen, so the outstanding access is
  // implied by the state rather than re-read from the EXMEM inputs.
  assign w_mem_busy = (r_state == MEM_WAIT) | EXMEM_MemRead_i | EXMEM_MemWrite_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_lu_inc        = 1'b0;
    w_fl_inc        = 1'b0;
    w_ms_inc        = 1'b0;
    PC_write_o      = 1'b0;
    IFID_write_o    = 1'b0;
    IFID_flush_o    = 1'b0;
    IDEX_bubble_o   = 1'b0;
    freeze_o        = 1'b1;
    dmem_req_o      = 1'b0;
    error_o         = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i) w_next_state = RUN;
      end

      RUN, MEM_WAIT: begin
        dmem_req_o = w_mem_busy;
        if (w_mem_busy && !dmem_ack_i) begin
          // Memory stall outranks everything: hold the whole pipe.
          w_ms_inc = 1'b1;
          if (r_state == RUN) begin
            w_next_state    = MEM_WAIT;
            w_wait_cnt_next = '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_next_state = ERROR;
          end else begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
          end
        end else begin
          // Memory is done (or idle): the back end advances this edge and
          // the front-end hazard/branch rules decide PC and IF/ID.
          freeze_o     = 1'b0;
          w_next_state = RUN;
          if (hazard_i) begin
            // A taken branch alongside a load-use stall is dropped here;
            // it is still in ID next cycle and resolves again.
            IDEX_bubble_o = 1'b1;
            w_lu_inc      = 1'b1;
          end else begin
            PC_write_o   = 1'b1;
            IFID_write_o = 1'b1;
            if (branch_taken_i) begin
              IFID_flush_o = 1'b1;
              w_fl_inc     = 1'b1;
            end
          end
        end
      end

      ERROR: begin
        error_o = 1'b1;
      end

      default: ;
    endcase
  end

  assign state_o = r_state;

  sat_counter #(.W(CNT_W)) u_loaduse_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_inc   (w_lu_inc),
    .o_count (loaduse_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_inc   (w_fl_inc),
    .o_count (flush_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_memstall_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_inc   (w_ms_inc),
    .o_count (memstall_cnt_o)
  );

endmodule
